// File: rtl/chacha_asic_top.sv
`default_nettype none
// ============================================================================
//  Module      : chacha_asic_top
//  Description : ChaCha20 (IETF) block engine. Assembles the 16-word state
//                from the sigma constants, key, counter and nonce. Key, nonce
//                and counter words come from the host chunk interface or from
//                the TRNG handshake. The engine performs one column or one
//                diagonal round per cycle, adds the initial state, XORs the
//                16 streamed input words and streams the 16 result words out.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst               clock, synchronous active-high reset
//    start / busy / done    operation control and status
//    in_state_*             input (plaintext) word stream, valid/ready
//    out_state_*            result word stream, valid/ready
//    use_streamed_*         source select for key / nonce / counter
//    chunk_type/valid/chunk host chunk word offered to the engine
//    chunk_index/request,
//    request_type           chunk word requested by the engine
//    trng_data/ready,
//    trng_request           random word handshake
//  ROUNDS must be even; each ROUND cycle is one column or one diagonal round.
// ============================================================================
module chacha_asic_top #(
  parameter int ROUNDS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [31:0] in_state_word,
  input  logic        in_state_valid,
  output logic        in_state_ready,
  output logic [31:0] out_state_word,
  output logic        out_state_valid,
  input  logic        out_state_ready,
  input  logic        use_streamed_key,
  input  logic        use_streamed_nonce,
  input  logic        use_streamed_counter,
  input  logic [1:0]  chunk_type,
  input  logic        chunk_valid,
  input  logic [31:0] chunk,
  output logic [4:0]  chunk_index,
  output logic        chunk_request,
  output logic [1:0]  request_type,
  input  logic [31:0] trng_data,
  input  logic        trng_ready,
  output logic        trng_request
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  localparam logic [1:0] TYPE_KEY   = 2'd0;
  localparam logic [1:0] TYPE_NONCE = 2'd1;
  localparam logic [1:0] TYPE_CTR   = 2'd2;

  localparam logic [31:0] SIGMA0 = 32'h61707865;
  localparam logic [31:0] SIGMA1 = 32'h3320646e;
  localparam logic [31:0] SIGMA2 = 32'h79622d32;
  localparam logic [31:0] SIGMA3 = 32'h6b206574;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_KEY   = 4'd1,
    S_NONCE = 4'd2,
    S_CTR   = 4'd3,
    S_LOAD  = 4'd4,
    S_ROUND = 4'd5,
    S_ADD   = 4'd6,
    S_OUT   = 4'd7,
    S_FIN   = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         idx_q, idx_d;     // word counter shared by load/in/out states
  logic [RW-1:0]      rnd_q, rnd_d;
  logic [15:0][31:0]  init_q, init_d;   // initial ChaCha state
  logic [15:0][31:0]  work_q, work_d;   // working state during rounds
  logic [15:0][31:0]  res_q, res_d;     // input words, then result words

  logic [15:0][31:0]  round_w;
  logic               load_take;
  logic [31:0]        load_word;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                      input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // One round on the working state. Lane i uses word i of each row; the
  // diagonal round shifts rows 1..3 by 1..3 lanes (2-bit wrap-around).
  logic [3:0]   ib, ic, id;
  logic [1:0]   lane;
  logic [127:0] qv;

  always_comb begin
    round_w = work_q;
    ib      = '0;
    ic      = '0;
    id      = '0;
    lane    = '0;
    qv      = '0;
    for (int i = 0; i < 4; i++) begin
      lane = 2'(i);
      ib   = {2'b01, rnd_q[0] ? lane + 2'd1 : lane};
      ic   = {2'b10, rnd_q[0] ? lane + 2'd2 : lane};
      id   = {2'b11, rnd_q[0] ? lane + 2'd3 : lane};
      qv   = qr(work_q[i], work_q[ib], work_q[ic], work_q[id]);
      round_w[i]  = qv[127:96];
      round_w[ib] = qv[95:64];
      round_w[ic] = qv[63:32];
      round_w[id] = qv[31:0];
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    rnd_d           = rnd_q;
    init_d          = init_q;
    work_d          = work_q;
    res_d           = res_q;
    busy            = 1'b0;
    done            = 1'b0;
    in_state_ready  = 1'b0;
    out_state_valid = 1'b0;
    out_state_word  = '0;
    chunk_request   = 1'b0;
    request_type    = '0;
    chunk_index     = '0;
    trng_request    = 1'b0;
    load_take       = 1'b0;
    load_word       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_KEY;
          idx_d     = '0;
          init_d[0] = SIGMA0;
          init_d[1] = SIGMA1;
          init_d[2] = SIGMA2;
          init_d[3] = SIGMA3;
        end
      end

      S_KEY: begin
        busy = 1'b1;
        if (use_streamed_key) begin
          chunk_request = 1'b1;
          request_type  = TYPE_KEY;
          chunk_index   = idx_q;
          load_take     = chunk_valid && (chunk_type == TYPE_KEY);
          load_word     = chunk;
        end else begin
          trng_request = 1'b1;
          load_take    = trng_ready;
          load_word    = trng_data;
        end
        if (load_take) begin
          init_d[4'd4 + idx_q[3:0]] = load_word;
          if (idx_q == 5'd7) begin
            state_d = S_NONCE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      S_NONCE: begin
        busy = 1'b1;
        if (use_streamed_nonce) begin
          chunk_request = 1'b1;
          request_type  = TYPE_NONCE;
          chunk_index   = idx_q;
          load_take     = chunk_valid && (chunk_type == TYPE_NONCE);
          load_word     = chunk;
        end else begin
          trng_request = 1'b1;
          load_take    = trng_ready;
          load_word    = trng_data;
        end
        if (load_take) begin
          init_d[4'd13 + idx_q[3:0]] = load_word;
          if (idx_q == 5'd2) begin
            state_d = S_CTR;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      S_CTR: begin
        busy = 1'b1;
        if (use_streamed_counter) begin
          chunk_request = 1'b1;
          request_type  = TYPE_CTR;
          chunk_index   = idx_q;
          if (chunk_valid && (chunk_type == TYPE_CTR)) begin
            init_d[12] = chunk;
            state_d    = S_LOAD;
            idx_d      = '0;
          end
        end else begin
          // Counter not supplied: block counter starts at zero.
          init_d[12] = '0;
          state_d    = S_LOAD;
          idx_d      = '0;
        end
      end

      S_LOAD: begin
        busy           = 1'b1;
        in_state_ready = 1'b1;
        if (in_state_valid) begin
          res_d[idx_q[3:0]] = in_state_word;
          if (idx_q == 5'd15) begin
            state_d = S_ROUND;
            idx_d   = '0;
            rnd_d   = '0;
            work_d  = init_q;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      S_ROUND: begin
        busy   = 1'b1;
        work_d = round_w;
        if (rnd_q == RW'(ROUNDS - 1)) begin
          state_d = S_ADD;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end

      S_ADD: begin
        busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
          res_d[i] = (work_q[i] + init_q[i]) ^ res_q[i];
        end
        state_d = S_OUT;
        idx_d   = '0;
      end

      S_OUT: begin
        busy            = 1'b1;
        out_state_valid = 1'b1;
        out_state_word  = res_q[idx_q[3:0]];
        if (out_state_ready) begin
          if (idx_q == 5'd15) begin
            state_d = S_FIN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rnd_q   <= '0;
      init_q  <= '0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
      init_q  <= init_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chacha_asic_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chacha_asic_top
//  Description : Self-checking bench for chacha_asic_top. A table of block
//                operations (RFC vector plus randomized ones) is checked
//                against a behavioural ChaCha20 block model; hand-written
//                sequences cover reset abort, output stalls, wrong chunk
//                types and start pulses while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha_asic_top;

  localparam int ROUNDS = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] in_state_word;
  logic        in_state_valid;
  logic        in_state_ready;
  logic [31:0] out_state_word;
  logic        out_state_valid;
  logic        out_state_ready;
  logic        use_streamed_key;
  logic        use_streamed_nonce;
  logic        use_streamed_counter;
  logic [1:0]  chunk_type;
  logic        chunk_valid;
  logic [31:0] chunk;
  logic [4:0]  chunk_index;
  logic        chunk_request;
  logic [1:0]  request_type;
  logic [31:0] trng_data;
  logic        trng_ready;
  logic        trng_request;

  always #5 clk = ~clk;

  chacha_asic_top #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_state_word(in_state_word), .in_state_valid(in_state_valid),
    .in_state_ready(in_state_ready), .out_state_word(out_state_word),
    .out_state_valid(out_state_valid), .out_state_ready(out_state_ready),
    .use_streamed_key(use_streamed_key), .use_streamed_nonce(use_streamed_nonce),
    .use_streamed_counter(use_streamed_counter), .chunk_type(chunk_type),
    .chunk_valid(chunk_valid), .chunk(chunk), .chunk_index(chunk_index),
    .chunk_request(chunk_request), .request_type(request_type),
    .trng_data(trng_data), .trng_ready(trng_ready), .trng_request(trng_request)
  );

  typedef struct packed {
    logic [7:0][31:0]  key;
    logic [31:0]       ctr;
    logic [2:0][31:0]  nonce;
    logic [15:0][31:0] din;
    logic [10:0][31:0] trng;
    logic              sk, sn, sc;
    logic              gaps, wrong_type, start_spam;
    logic [7:0]        in_hold, out_stall;
    logic [15:0][31:0] exp_w;
    logic [7:0]        exp_trng;
  } vec_t;

  localparam int QI [8][4] = '{
    '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
  };

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] got [16];
  int          got_n, done_n, trng_n;
  bit          chunk_seen;
  vec_t        vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic any_out();
    return busy | done | in_state_ready | (|out_state_word) | out_state_valid |
           (|chunk_index) | chunk_request | (|request_type) | trng_request;
  endfunction

  function automatic logic [127:0] mqr(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    logic [31:0] x, y, z, w;
    x = a; y = b; z = c; w = d;
    x += y; w ^= x; w = {w[15:0], w[31:16]};
    z += w; y ^= z; y = {y[19:0], y[31:20]};
    x += y; w ^= x; w = {w[23:0], w[31:24]};
    z += w; y ^= z; y = {y[24:0], y[31:25]};
    return {x, y, z, w};
  endfunction

  // Full ChaCha20 block: ROUNDS/2 double rounds, feed-forward, XOR with data.
  function automatic logic [15:0][31:0] ref_block(input logic [7:0][31:0] k, input logic [31:0] c,
                                                  input logic [2:0][31:0] n, input logic [15:0][31:0] d);
    logic [31:0]       s [16];
    logic [31:0]       x [16];
    logic [127:0]      q;
    logic [15:0][31:0] o;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[i];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[i];
    for (int i = 0; i < 16; i++) x[i] = s[i];
    for (int r = 0; r < ROUNDS / 2; r++) begin
      for (int j = 0; j < 8; j++) begin
        q = mqr(x[QI[j][0]], x[QI[j][1]], x[QI[j][2]], x[QI[j][3]]);
        x[QI[j][0]] = q[127:96]; x[QI[j][1]] = q[95:64];
        x[QI[j][2]] = q[63:32];  x[QI[j][3]] = q[31:0];
      end
    end
    for (int i = 0; i < 16; i++) o[i] = (x[i] + s[i]) ^ d[i];
    return o;
  endfunction

  function automatic logic [31:0] word_for(input vec_t v, input logic [1:0] t, input logic [4:0] idx);
    if (t == 2'd0) return v.key[idx[2:0]];
    if (t == 2'd1) return (idx < 5'd3) ? v.nonce[idx[1:0]] : 32'h0;
    return v.ctr;
  endfunction

  // Drives one block operation, answering every request from the vector.
  // Starts and returns at a falling edge with the engine idle.
  task automatic run_op(input vec_t v, input int abort_after);
    int          in_n, hold_left, stall_left, wt_phase, ab_cnt;
    bit          fin, stalled, hold_on, aborted;
    logic [31:0] stall_word;
    in_n = 0; hold_left = int'(v.in_hold); stall_left = 0; wt_phase = 0; ab_cnt = 0;
    fin = 0; stalled = 0; hold_on = 0; aborted = 0; stall_word = '0;
    got_n = 0; done_n = 0; trng_n = 0; chunk_seen = 0;
    use_streamed_key = v.sk; use_streamed_nonce = v.sn; use_streamed_counter = v.sc;
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      chunk_valid = 0; chunk_type = 0; chunk = 0; trng_ready = 0; trng_data = 0;
      in_state_valid = 0; in_state_word = 0; out_state_ready = 0; start = 0;
      if (done) begin
        done_n++;
        fin = 1;
      end else begin
        if (abort_after > 0 && in_n == 16) ab_cnt++;
        if (abort_after > 0 && ab_cnt == abort_after) begin
          chk("abort_busy_before", {31'd0, busy}, 32'd1);
          rst = 1'b1;
          @(negedge clk);
          chk("abort_outputs_zero", {31'd0, any_out()}, 32'd0);
          rst = 1'b0;
          for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) done_n++;
          end
          chk("abort_no_done", done_n, 32'd0);
          fin = 1; aborted = 1;
        end else begin
          if (chunk_request) begin
            chunk_seen = 1;
            if (v.wrong_type && wt_phase == 0 && request_type == 2'd0 && chunk_index == 5'd2) begin
              chunk_valid = 1; chunk_type = 2'd1; chunk = 32'hdeadbeef; wt_phase = 1;
            end else if (wt_phase == 1) begin
              chk("wrong_type_index_hold", {27'd0, chunk_index}, 32'd2);
              chunk_valid = 1; chunk_type = request_type;
              chunk = word_for(v, request_type, chunk_index); wt_phase = 2;
            end else begin
              if (wt_phase == 2) begin
                chk("wrong_type_index_adv", {27'd0, chunk_index}, 32'd3);
                wt_phase = 3;
              end
              if (!v.gaps || $urandom_range(0, 2) != 0) begin
                chunk_valid = 1; chunk_type = request_type;
                chunk = word_for(v, request_type, chunk_index);
              end else if ($urandom_range(0, 1) == 1) begin
                chunk_valid = 1; chunk_type = request_type + 2'd1; chunk = $urandom;
              end
            end
          end
          if (trng_request) begin
            chk("req_exclusive", {31'd0, chunk_request}, 32'd0);
            if (!v.gaps || $urandom_range(0, 1) == 1) begin
              trng_ready = 1;
              trng_data = (trng_n < 11) ? v.trng[trng_n] : $urandom;
              trng_n++;
            end
          end
          if (hold_left > 0 && (in_state_ready || hold_on)) begin
            hold_on = 1;
            hold_left--;
            if (hold_left == 0) chk("load_stall_busy_ready", {30'd0, busy, in_state_ready}, 32'd3);
          end else if (in_state_ready && in_n < 16) begin
            if (!v.gaps || $urandom_range(0, 2) != 0) begin
              in_state_valid = 1; in_state_word = v.din[in_n]; in_n++;
            end
          end
          if (out_state_valid) begin
            if (stall_left > 0) begin
              chk("stall_word_stable", out_state_word, stall_word);
              stall_left--;
            end else if (v.out_stall > 0 && !stalled && got_n == 5) begin
              stalled = 1; stall_word = out_state_word; stall_left = int'(v.out_stall) - 1;
            end else if (!v.gaps || $urandom_range(0, 2) != 0) begin
              out_state_ready = 1;
              if (got_n < 16) got[got_n] = out_state_word;
              got_n++;
            end
          end
          if (v.start_spam && busy && $urandom_range(0, 2) == 0) start = 1;
        end
      end
      if (!fin) @(negedge clk);
    end
    chk("op_finished", {31'd0, fin}, 32'd1);
    start = 0; chunk_valid = 0; trng_ready = 0; in_state_valid = 0; out_state_ready = 0;
    if (!aborted) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (done) done_n++;
      end
    end
  endtask

  task automatic check_block(input int t);
    chk($sformatf("v%0d_word_count", t), got_n, 32'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("v%0d_w%0d", t, i), got[i], vecs[t].exp_w[i]);
    chk($sformatf("v%0d_done_count", t), done_n, 32'd1);
    chk($sformatf("v%0d_trng_count", t), trng_n, {24'd0, vecs[t].exp_trng});
    chk($sformatf("v%0d_chunk_seen", t), {31'd0, chunk_seen},
        {31'd0, vecs[t].sk | vecs[t].sn | vecs[t].sc});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][31:0] k;
    logic [2:0][31:0] n;
    int               tp;
    vec_t             va;

    rst = 1; start = 0; in_state_word = 0; in_state_valid = 0; out_state_ready = 0;
    use_streamed_key = 0; use_streamed_nonce = 0; use_streamed_counter = 0;
    chunk_type = 0; chunk_valid = 0; chunk = 0; trng_data = 0; trng_ready = 0;

    // ---------------- vector table ----------------
    for (int t = 0; t < 5; t++) begin
      vecs[t] = '0;
      for (int i = 0; i < 8; i++)  vecs[t].key[i] = $urandom;
      for (int i = 0; i < 3; i++)  vecs[t].nonce[i] = $urandom;
      for (int i = 0; i < 16; i++) vecs[t].din[i] = $urandom;
      for (int i = 0; i < 11; i++) vecs[t].trng[i] = $urandom;
      vecs[t].ctr = $urandom;
    end
    for (int i = 0; i < 8; i++)
      vecs[0].key[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    vecs[0].ctr = 32'h00000001;
    vecs[0].nonce[0] = 32'h09000000; vecs[0].nonce[1] = 32'h4a000000; vecs[0].nonce[2] = 32'h0;
    vecs[0].din = '0;
    {vecs[0].sk, vecs[0].sn, vecs[0].sc} = 3'b111;
    {vecs[1].sk, vecs[1].sn, vecs[1].sc} = 3'b111; vecs[1].gaps = 1; vecs[1].wrong_type = 1;
    {vecs[2].sk, vecs[2].sn, vecs[2].sc} = 3'b000; vecs[2].in_hold = 8'd10;
    {vecs[3].sk, vecs[3].sn, vecs[3].sc} = 3'b011; vecs[3].gaps = 1; vecs[3].out_stall = 8'd5;
    {vecs[4].sk, vecs[4].sn, vecs[4].sc} = 3'b100; vecs[4].start_spam = 1;
    for (int t = 0; t < 5; t++) begin
      tp = 0;
      k = vecs[t].key;
      n = vecs[t].nonce;
      if (!vecs[t].sk) for (int i = 0; i < 8; i++) begin k[i] = vecs[t].trng[tp]; tp++; end
      if (!vecs[t].sn) for (int i = 0; i < 3; i++) begin n[i] = vecs[t].trng[tp]; tp++; end
      vecs[t].exp_trng = 8'(tp);
      vecs[t].exp_w = ref_block(k, vecs[t].sc ? vecs[t].ctr : 32'h0, n, vecs[t].din);
    end

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", {31'd0, any_out()}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_outputs_zero", {31'd0, any_out()}, 32'd0);

    // ---------------- table-driven block operations ----------------
    for (int t = 0; t < 5; t++) begin
      run_op(vecs[t], 0);
      check_block(t);
      chk($sformatf("v%0d_idle_after", t), {31'd0, busy}, 32'd0);
      if (t == 0) begin
        chk("rfc_w0", got[0], 32'he4e7f110);
        chk("rfc_w1", got[1], 32'h15593bd1);
        chk("rfc_w15", got[15], 32'h4e3c50a2);
      end
    end

    // ---------------- reset during ROUND, then a clean operation ----------------
    va = vecs[1];
    va.gaps = 0; va.wrong_type = 0;
    run_op(va, 5);
    run_op(vecs[0], 0);
    check_block(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chacha_asic_top.md
Name: chacha_asic_top

Overview:
- ChaCha20 (IETF variant) block-cipher engine. Builds the 16-word state from constants, key, counter and nonce.
- Key, nonce and counter words come either from a host chunk-streaming interface or from an external TRNG handshake.
- Runs the rounds, adds the initial state, XORs with 16 host-streamed input words and streams 16 result words out.
- Sits between the host bus and the TRNG in the crypto ASIC top level.

Parameters:
- ROUNDS, 20, total ChaCha rounds; must be even. Each cycle performs one column round or one diagonal round.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one block operation; sampled only in IDLE
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- in_state_word  in  32  input (plaintext) word
- in_state_valid  in  1  input word valid
- in_state_ready  out  1  engine accepts input word
- out_state_word  out  32  result word
- out_state_valid  out  1  result word valid
- out_state_ready  in  1  sink accepts result word
- use_streamed_key  in  1  1: key from chunk interface; 0: from TRNG
- use_streamed_nonce  in  1  1: nonce from chunk interface; 0: from TRNG
- use_streamed_counter  in  1  1: counter from chunk interface; 0: counter = 0
- chunk_type  in  2  type of offered chunk: 0 key, 1 nonce, 2 counter
- chunk_valid  in  1  chunk word valid
- chunk  in  32  chunk word
- chunk_index  out  5  index of requested word within its type
- chunk_request  out  1  engine requests a chunk word
- request_type  out  2  type being requested (same encoding as chunk_type)
- trng_data  in  32  random word
- trng_ready  in  1  trng_data valid
- trng_request  out  1  engine requests a random word

Behaviour:
- Reset: every output 0, FSM = IDLE, state/working registers cleared. Reset has priority in any state and aborts mid-operation with no done pulse.
- State layout:
  - w0..w3 = 61707865, 3320646e, 79622d32, 6b206574
  - w4..w11 = key words 0..7
  - w12 = counter
  - w13..w15 = nonce words 0..2
- FSM: IDLE -> KEY -> NONCE -> CTR -> LOAD_IN -> ROUND -> ADD -> OUT -> FIN -> IDLE.
- IDLE: start=1 moves to KEY next cycle and busy=1 from that cycle. start is ignored while busy.
- Word-load states (KEY 8 words, NONCE 3 words, CTR 1 word):
  - Streamed source: chunk_request=1, request_type = state's type, chunk_index = word count (starts at 0 each state). A word is accepted on a cycle with chunk_valid=1 and chunk_type==request_type. A type mismatch is ignored and the engine keeps waiting. Index increments per accepted word; the FSM leaves the state in the cycle after the last word is accepted.
  - TRNG source: trng_request held 1 until a cycle with trng_ready=1. trng_data is captured that cycle. One word per handshake, no timeout.
  - CTR with use_streamed_counter=0: counter := 0, the state is passed through in one cycle, and no request is made.
  - chunk_request and trng_request are never both 1.
- LOAD_IN: in_state_ready=1. Words 0..15 are captured on in_state_valid && in_state_ready; the state exits after word 15.
- ROUND: working copy = initial state. Odd cycles do column QRs (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15); even cycles do diagonal QRs (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
  - QR: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
  - All additions are mod 2^32. ROUNDS cycles total.
- ADD: out[i] = (working[i] + initial[i]) mod 2^32, XOR input word i. One cycle.
- OUT: out_state_valid=1 with word i, held stable until out_state_ready=1. The next word is presented the following cycle; words go in order 0..15.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. Result registers are kept until the next start.
- Minimum latency with all sources ready: start to done ≈ 12 + 16 + ROUNDS + 1 + 16 + 1 cycles.

Test Plan:
- RFC 7539 §2.3.2 vector: streamed key 03020100,07060504,…,1f1e1d1c; counter 00000001; nonce 09000000,4a000000,00000000; 16 input words 0 -> out words 0..15, word0 e4e7f110, word1 15593bd1, word15 4e3c50a2, then done pulse.
- All use_streamed_*=0, TRNG answering every request -> exactly 11 trng handshakes and no chunk_request. The engine then stalls in LOAD_IN with busy=1 and in_state_ready=1 until input is given.
- Chunk offered with wrong chunk_type (nonce while key requested) -> not accepted, chunk_index unchanged; the correct type is then accepted and the index advances.
- out_state_ready held 0 for 5 cycles mid-output -> out_state_word/valid stable, no word lost or duplicated.
- rst asserted during ROUND -> next cycle all outputs 0, IDLE, no done. A new start completes normally.
- start pulsed while busy -> ignored, exactly one done per accepted start.
